demux_2_16_buf: RTL
===================

DEMUX_2_16_BUF -- requirements
Module: demux_2_16_buf

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the data path width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port Demux_input_16, input, WIDTH bits: the source data word.
REQ-005 The module SHALL have port select, input, 1 bit: the destination channel for Demux_input_16 (0 or 1).
REQ-006 The module SHALL have port in_valid, input, 1 bit: the source offers a word this cycle.
REQ-007 The module SHALL have port in_ready, output, 1 bit: the selected channel can accept a word this cycle.
REQ-008 The module SHALL have ports Demux_out_16_0 and Demux_out_16_1, output, WIDTH bits each: the head word of channel 0 and channel 1.
REQ-009 The module SHALL have ports out_valid_0 and out_valid_1, output, 1 bit each: the channel head word is valid.
REQ-010 The module SHALL have ports out_ready_0 and out_ready_1, input, 1 bit each: the consumer takes the head word.
REQ-011 The module SHALL have ports occupancy_0 and occupancy_1, output, 2 bits each: the stored entry count (0..2) per channel.

Function
REQ-012 Each channel SHALL be an independent 2-entry FIFO with registered storage, a 1-bit read pointer, a 1-bit write pointer and a 2-bit count.
REQ-013 in_ready SHALL equal (count[select] < 2), evaluated combinationally from the current select.
REQ-014 A push SHALL occur when in_valid && in_ready; Demux_input_16 is written into the write-pointer entry of channel[select], and that write pointer toggles.
REQ-015 The non-selected channel SHALL never be written, and its state SHALL be unaffected by the source handshake.
REQ-016 out_valid_k SHALL equal (count_k != 0).
REQ-017 Demux_out_16_k SHALL present the read-pointer entry of channel k when out_valid_k is 1, and WIDTH'h0 when it is 0.
REQ-018 A pop on channel k SHALL occur when out_valid_k && out_ready_k; the read pointer of channel k toggles.
REQ-019 Latency SHALL be one cycle: a word pushed at edge N is visible on Demux_out_16_k with out_valid_k=1 after edge N; there is no combinational input-to-output path.
REQ-020 Per-channel count update rules:
- push only: +1
- pop only: -1
- push and pop in the same cycle: unchanged
REQ-021 At count 2, in_ready SHALL be 0 for that channel; a simultaneous pop SHALL free the slot only from the next cycle (no same-cycle bypass).
REQ-022 At count 1, a simultaneous push and pop SHALL keep count 1 and present the newly pushed word after the edge.
REQ-023 Pointers SHALL wrap modulo 2; word order within each channel SHALL be preserved.
REQ-024 out_ready_k asserted while out_valid_k is 0 SHALL have no effect.
REQ-025 Both channels SHALL be able to pop in the same cycle, and a push to one channel SHALL proceed concurrently with a pop on the other.
REQ-026 occupancy_k SHALL equal count_k.

Reset
REQ-027 Assertion of reset_n low SHALL immediately, without waiting for clk, clear all counts, pointers and storage to 0.
REQ-028 While reset_n is low, the module SHALL drive in_ready=0, out_valid_0=out_valid_1=0, Demux_out_16_0=Demux_out_16_1=0 and occupancy_0=occupancy_1=0.
REQ-029 After reset_n rises, the first push SHALL be possible at the first rising clk edge.
REQ-030 Reset asserted mid-operation SHALL discard all stored words, with no partial pop or push.

Verification
REQ-031 Single-word latency: push 16'h1234 with select=0 at edge N -> out_valid_0=1 and Demux_out_16_0=16'h1234 after edge N; out_valid_1 stays 0.
REQ-032 Fill and backpressure: with out_ready_1=0, push 16'hA001 then 16'hA002 with select=1 -> occupancy_1=2 and in_ready=0 while select=1; in_ready=1 when select=0.
REQ-033 Full with simultaneous pop: at occupancy_1=2, raise out_ready_1 -> first cycle pops 16'hA001 only; the next push then succeeds; pop order is 16'hA002 then the new word.
REQ-034 Simultaneous push and pop: at occupancy_0=1 holding 16'h0BEE, push 16'h0CAF with out_ready_0=1 -> occupancy_0 stays 1 and Demux_out_16_0=16'h0CAF.
REQ-035 Concurrent channels: alternate select each cycle with both out_ready held 1 for 8 words -> each channel delivers its 4 words in order with no stall.
REQ-036 Asynchronous reset mid-stream: drop reset_n between edges with both channels at occupancy 2 -> all outputs read 0 immediately, before the next edge.

Source files
------------

// File: rtl/demux_2_16_buf.sv
// demux_2_16_buf
// Routes one source word stream into two independent 2-entry FIFOs.
// `select` picks the destination channel. Each channel presents its
// oldest stored word with a valid/ready handshake to its own consumer.
// All outputs come from registers, or from register-selected muxes, so
// no input reaches an output in the same cycle. The one exception is
// in_ready, which depends on the current select by design.

module demux_2_16_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] Demux_input_16,
  input  logic             select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Demux_out_16_0,
  output logic [WIDTH-1:0] Demux_out_16_1,
  output logic             out_valid_0,
  output logic             out_valid_1,
  input  logic             out_ready_0,
  input  logic             out_ready_1,
  output logic [1:0]       occupancy_0,
  output logic [1:0]       occupancy_1
);

  localparam logic [1:0] CNT_FULL  = 2'd2;
  localparam logic [1:0] CNT_EMPTY = 2'd0;

  // Per-channel storage: mem[channel][entry]
  logic [WIDTH-1:0] mem_q [2][2];
  logic [WIDTH-1:0] mem_d [2][2];

  // One pointer bit per channel, packed as [channel]
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;

  // Stored entry count per channel (0..2)
  logic [1:0] count_q [2];
  logic [1:0] count_d [2];

  // Per-channel handshake events, indexed by channel
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] chan_valid;
  logic [1:0] chan_ready;
  logic       sel_has_room;

  // Handshake decode: source readiness for the selected channel, and push/pop per channel
  always_comb begin
    chan_ready   = {out_ready_1, out_ready_0};
    chan_valid   = '0;
    pop          = '0;
    sel_has_room = (count_q[select] < CNT_FULL);
    in_ready     = reset_n && sel_has_room;
    push[0]      = in_valid && in_ready && !select;
    push[1]      = in_valid && in_ready && select;
    for (int k = 0; k < 2; k++) begin
      chan_valid[k] = (count_q[k] != CNT_EMPTY);
      pop[k]        = chan_valid[k] && chan_ready[k];
    end
  end

  // Next-state: write at the write pointer, advance pointers, and keep the count in step with push/pop
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    for (int k = 0; k < 2; k++) begin
      if (push[k]) begin
        mem_d[k][wr_ptr_q[k]] = Demux_input_16;
        wr_ptr_d[k]           = ~wr_ptr_q[k];
      end
      if (pop[k]) begin
        rd_ptr_d[k] = ~rd_ptr_q[k];
      end
      unique case ({push[k], pop[k]})
        2'b10:   count_d[k] = count_q[k] + 2'd1;
        2'b01:   count_d[k] = count_q[k] - 2'd1;
        default: count_d[k] = count_q[k];
      endcase
    end
  end

  // State registers; reset clears everything at once so stored words are dropped without waiting for a clock edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int e = 0; e < 2; e++) begin
          mem_q[k][e] <= '0;
        end
        count_q[k] <= CNT_EMPTY;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Output view: head word only while valid, zero otherwise; occupancy mirrors the count
  always_comb begin
    out_valid_0    = chan_valid[0];
    out_valid_1    = chan_valid[1];
    Demux_out_16_0 = chan_valid[0] ? mem_q[0][rd_ptr_q[0]] : '0;
    Demux_out_16_1 = chan_valid[1] ? mem_q[1][rd_ptr_q[1]] : '0;
    occupancy_0    = count_q[0];
    occupancy_1    = count_q[1];
  end

endmodule
